reg_op_sequencer: RTL and testbench

Command sequencer that drives the control side of the 4-bit hold/clear/complement/load register. It accepts operation requests over a valid/ready handshake and buffers them in a 4-entry FIFO. It issues each request to the register's `sel`/`I` inputs for exactly one clock, then reads back the register output `A` and returns it as a one-cycle response. It sits between a host/test controller and the register instance and serialises register operations.

---
 rtl/reg_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_reg_op_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// Serialises hold/clear/complement/load requests onto a 4-bit register and returns its readback.
// Optional shadow-model consistency check is enabled by defining REG_OP_MODEL_CHECK_EN.
module reg_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [1:0] sel,
    output logic [3:0] I,
    input  logic [3:0] A,
    output logic       rsp_valid,
    output logic [3:0] rsp_data,
    output logic       busy,
    output logic       mismatch
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10
    } state_t;

    logic [5:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    state_t        state_r;
    logic [1:0]    sel_r;
    logic [3:0]    i_r;
    logic          rsp_valid_r;
    logic [3:0]    rsp_data_r;
    logic          busy_r;

    logic          cmd_ready_s;
    logic          push_s;
    logic          pop_s;
    state_t        state_next_s;
    logic [AW:0]   count_next_s;
    logic [5:0]    head_s;

    // Handshake, pop decision, next state and next FIFO occupancy.
    always_comb begin
        cmd_ready_s  = (count_r < CNT_FULL);
        push_s       = cmd_valid && cmd_ready_s;
        pop_s        = 1'b0;
        state_next_s = state_r;
        head_s       = mem_r[rd_ptr_r];
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_CAPTURE;
            ST_CAPTURE: begin
                if (count_r != '0) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Command storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_op, cmd_data};
        end
    end

    // Sequencer FSM with FIFO pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            sel_r       <= 2'b00;
            i_r         <= 4'h0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 4'h0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            busy_r  <= (state_next_s != ST_IDLE) || (count_next_s != '0);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                sel_r    <= head_s[5:4];
                i_r      <= head_s[3:0];
            end else begin
                sel_r    <= 2'b00;
                i_r      <= 4'h0;
            end
            // A is stable during CAPTURE, so sample it at that state's closing edge.
            if (state_r == ST_CAPTURE) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= A;
            end else begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

`ifdef REG_OP_MODEL_CHECK_EN
    logic [3:0] shadow_r;
    logic       shadow_valid_r;
    logic       mismatch_r;

    // Shadow of the register; it has no reset, so trust it only after clear or load.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r       <= 4'h0;
            shadow_valid_r <= 1'b0;
            mismatch_r     <= 1'b0;
        end else begin
            if (state_r == ST_ISSUE) begin
                case (sel_r)
                    2'b01: begin
                        shadow_r       <= 4'h0;
                        shadow_valid_r <= 1'b1;
                    end
                    2'b10: shadow_r <= ~shadow_r;
                    2'b11: begin
                        shadow_r       <= i_r;
                        shadow_valid_r <= 1'b1;
                    end
                    default: shadow_r <= shadow_r;
                endcase
            end
            if ((state_r == ST_CAPTURE) && shadow_valid_r && (A != shadow_r)) begin
                mismatch_r <= 1'b1;
            end
        end
    end

    assign mismatch = mismatch_r;
`else
    assign mismatch = 1'b0;
`endif

    assign cmd_ready = cmd_ready_s;
    assign sel       = sel_r;
    assign I         = i_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a behavioural model of the 4-bit register on A.
module tb_reg_op_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [1:0] sel;
    logic [3:0] I;
    logic [3:0] A;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       busy;
    logic       mismatch;

`ifdef REG_OP_MODEL_CHECK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    reg_op_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .sel(sel), .I(I), .A(A),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // Hold/clear/complement/load register driven by sel/I; force_en overrides its output.
    logic [3:0] reg_a    = 4'h0;
    logic       force_en = 1'b0;
    always @(posedge clk) begin
        case (sel)
            2'b01:   reg_a <= 4'h0;
            2'b10:   reg_a <= ~reg_a;
            2'b11:   reg_a <= I;
            default: reg_a <= reg_a;
        endcase
    end
    assign A = force_en ? 4'hF : reg_a;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every response with its edge number.
    logic [3:0] rsp_q[$];
    int         rsp_cyc_q[$];
    always @(posedge clk) begin
        #1;
        if (rsp_valid === 1'b1) begin
            rsp_q.push_back(rsp_data);
            rsp_cyc_q.push_back(cyc);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("push_timeout", 8'd0, 8'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int         c0;
    logic [3:0] exp_b2b [4] = '{4'h5, 4'hA, 4'h0, 4'h0};
    logic [3:0] exp_fill[7] = '{4'h1, 4'hE, 4'h7, 4'h8, 4'h8, 4'h0, 4'hC};

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0;
        step(); step();
        chk("rst_sel", sel, 8'h0);
        chk("rst_I", I, 8'h0);
        chk("rst_rsp_valid", rsp_valid, 8'h0);
        chk("rst_rsp_data", rsp_data, 8'h0);
        chk("rst_mismatch", mismatch, 8'h0);
        chk("rst_cmd_ready", cmd_ready, 8'h1);
        chk("rst_busy", busy, 8'h0);
        rst = 1'b0;

        // Single load 0xA: latency and one-cycle issue.
        rsp_q.delete(); rsp_cyc_q.delete();
        push(2'b11, 4'hA);
        c0 = cyc;
        chk("t0_busy", busy, 8'h1);
        chk("t0_sel", sel, 8'h0);
        step();
        chk("t1_sel", sel, 8'h3);
        chk("t1_I", I, 8'hA);
        step();
        chk("t2_sel", sel, 8'h0);
        chk("t2_I", I, 8'h0);
        chk("t2_rsp_valid", rsp_valid, 8'h0);
        step();
        chk("t3_rsp_valid", rsp_valid, 8'h1);
        chk("t3_rsp_data", rsp_data, 8'hA);
        step();
        chk("t4_rsp_valid", rsp_valid, 8'h0);
        chk("t4_busy", busy, 8'h0);
        chk("load_rsp_count", 8'(rsp_q.size()), 8'd1);
        if (rsp_cyc_q.size() == 1) chk("load_latency", 8'(rsp_cyc_q[0] - c0), 8'd3);

        // Back-to-back load 5, complement, clear, hold.
        rsp_q.delete(); rsp_cyc_q.delete();
        push(2'b11, 4'h5);
        push(2'b10, 4'h0);
        push(2'b01, 4'h0);
        push(2'b00, 4'h0);
        repeat (12) step();
        chk("b2b_count", 8'(rsp_q.size()), 8'd4);
        if (rsp_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("b2b_data%0d", i), rsp_q[i], exp_b2b[i]);
            for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), 8'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 8'd2);
        end
        chk("b2b_busy_end", busy, 8'h0);

        // Continuous pushes until the FIFO fills, then drain in order.
        rsp_q.delete(); rsp_cyc_q.delete();
        push(2'b11, 4'h1);
        push(2'b10, 4'h0);
        push(2'b11, 4'h7);
        push(2'b10, 4'h0);
        push(2'b00, 4'h0);
        push(2'b01, 4'h0);
        push(2'b11, 4'hC);
        chk("full_cmd_ready", cmd_ready, 8'h0);
        chk("full_busy", busy, 8'h1);
        repeat (20) step();
        chk("drain_cmd_ready", cmd_ready, 8'h1);
        chk("drain_busy", busy, 8'h0);
        chk("fill_count", 8'(rsp_q.size()), 8'd7);
        if (rsp_q.size() == 7) begin
            for (int i = 0; i < 7; i++) chk($sformatf("fill_data%0d", i), rsp_q[i], exp_fill[i]);
        end

        // Reset during ISSUE of load 0x3 aborts it without a response.
        rsp_q.delete(); rsp_cyc_q.delete();
        push(2'b11, 4'h3);
        step();
        chk("abort_issue_sel", sel, 8'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_sel", sel, 8'h0);
        chk("abort_I", I, 8'h0);
        chk("abort_busy", busy, 8'h0);
        chk("abort_cmd_ready", cmd_ready, 8'h1);
        repeat (6) step();
        chk("abort_no_rsp", 8'(rsp_q.size()), 8'd0);

        // Shadow check: hold before any load is ignored, a forced wrong A is flagged and sticky.
        push(2'b00, 4'h0);
        repeat (6) step();
        chk("hold_pre_load_mm", mismatch, 8'h0);
        chk("hold_pre_load_rsp", 8'(rsp_q.size()), 8'd1);
        if (rsp_q.size() == 1) chk("hold_pre_load_data", rsp_q[0], 8'h3);
        force_en = 1'b1;
        push(2'b11, 4'h3);
        repeat (6) step();
        chk("forced_mm", mismatch, EXP_MM);
        if (rsp_q.size() == 2) chk("forced_data", rsp_q[1], 8'hF);
        force_en = 1'b0;
        push(2'b00, 4'h0);
        repeat (6) step();
        chk("sticky_mm", mismatch, EXP_MM);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mm_cleared", mismatch, 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
